// File: rtl/fetch_npc_stage_if.sv
// fetch_npc_stage_if: ID-side control and fetch/ID data bundle of fetch_npc_stage.
// Carries the Likely input only when BRANCH_LIKELY_EN is defined.
interface fetch_npc_stage_if;
   logic        Stall;
   logic [1:0]  NPCOp;
   logic        Cmp;
   logic [25:0] Imm26;
   logic [31:0] RData1;
   logic [31:0] Instr_F;
   logic [31:0] PC_F;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [31:0] PC8_D;
   logic        AdEL_F;
`ifdef BRANCH_LIKELY_EN
   logic        Likely;
`endif
   modport master (
`ifdef BRANCH_LIKELY_EN
      output Likely,
`endif
      output Stall, NPCOp, Cmp, Imm26, RData1, Instr_F,
      input  PC_F, Instr_D, PC_D, PC8_D, AdEL_F
   );
   modport slave (
`ifdef BRANCH_LIKELY_EN
      input  Likely,
`endif
      input  Stall, NPCOp, Cmp, Imm26, RData1, Instr_F,
      output PC_F, Instr_D, PC_D, PC8_D, AdEL_F
   );
endinterface

// File: rtl/fetch_npc_stage.sv
// fetch_npc_stage: PC register, next-PC select and IF/ID register with one delay slot.
// Define BRANCH_LIKELY_EN to nullify the delay slot of a not-taken branch-likely.
module fetch_npc_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic               clk,
   input logic               reset,
   fetch_npc_stage_if.slave  bus
);
   logic [31:0] pc_f, instr_d, pc_d, seq, br_tgt, j_tgt, npc;
   logic [15:0] imm16;
   logic        nullify;
   assign imm16  = bus.Imm26[15:0];
   assign seq    = pc_f + 32'd4;
   assign br_tgt = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign j_tgt  = {pc_d[31:28], bus.Imm26, 2'b00};
   always_comb
      npc = bus.NPCOp == 2'd0 ? seq :
            bus.NPCOp == 2'd1 ? (bus.Cmp ? br_tgt : seq) :
            bus.NPCOp == 2'd2 ? j_tgt : bus.RData1;
`ifdef BRANCH_LIKELY_EN
   // Not-taken likely already selects pc_f+4; only the delay slot is squashed.
   assign nullify = bus.NPCOp == 2'd1 && bus.Likely && !bus.Cmp;
`else
   assign nullify = 1'b0;
`endif
   always_ff @(posedge clk)
      if (reset) begin
         pc_f    <= RESET_PC;
         instr_d <= NOP_INSTR;
         pc_d    <= 32'd0;
      end else if (!bus.Stall) begin
         pc_f    <= npc;
         instr_d <= nullify ? NOP_INSTR : bus.Instr_F;
         pc_d    <= pc_f;
      end
   assign bus.PC_F    = pc_f;
   assign bus.Instr_D = instr_d;
   assign bus.PC_D    = pc_d;
   assign bus.PC8_D   = pc_d + 32'd8;
   assign bus.AdEL_F  = pc_f[1:0] != 2'b00;
endmodule

// File: tb/tb_fetch_npc_stage.sv
// tb_fetch_npc_stage: directed plus random stimulus checked against a behavioural PC model.
module tb_fetch_npc_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0, cmp = 1'b0, likely = 1'b0;
   logic [1:0]  npcop = 2'd0;
   logic [25:0] imm26 = 26'd0;
   logic [31:0] rdata1 = 32'd0;
   logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_pcd = 32'd0;
   int checks = 0, passed = 0, fails = 0;
`ifdef BRANCH_LIKELY_EN
   localparam bit LIKELY_EN = 1'b1;
`else
   localparam bit LIKELY_EN = 1'b0;
`endif
   fetch_npc_stage_if bus ();
   fetch_npc_stage dut (.clk(clk), .reset(reset), .bus(bus));
   assign bus.Stall   = stall;
   assign bus.NPCOp   = npcop;
   assign bus.Cmp     = cmp;
   assign bus.Imm26   = imm26;
   assign bus.RData1  = rdata1;
   assign bus.Instr_F = ~bus.PC_F;
`ifdef BRANCH_LIKELY_EN
   assign bus.Likely  = likely;
`endif
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc_f"}, bus.PC_F, m_pc);
      chk({tag, ".instr_d"}, bus.Instr_D, m_instr);
      chk({tag, ".pc_d"}, bus.PC_D, m_pcd);
      chk({tag, ".pc8_d"}, bus.PC8_D, m_pcd + 32'd8);
      chk({tag, ".adel"}, {31'd0, bus.AdEL_F}, {31'd0, (m_pc % 4) != 0});
   endtask

   // One clock edge: advance the reference model from the inputs held across it, then compare.
   task automatic tick(input string tag);
      logic [31:0] nxt;
      @(posedge clk);
      if (reset) begin
         m_pc = 32'h3000; m_instr = 32'd0; m_pcd = 32'd0;
      end else if (!stall) begin
         case (npcop)
            2'd0: nxt = m_pc + 4;
            2'd1: nxt = cmp ? m_pcd + 4 + 32'($signed(imm26[15:0])) * 4 : m_pc + 4;
            2'd2: nxt = (m_pcd & 32'hF000_0000) | (32'(imm26) * 4);
            default: nxt = rdata1;
         endcase
         m_instr = (LIKELY_EN && npcop == 2'd1 && likely && !cmp) ? 32'd0 : ~m_pc;
         m_pcd = m_pc;
         m_pc = nxt;
      end
      #1;
      chk_all(tag);
   endtask

   task automatic restart();
      reset = 1'b1; stall = 1'b0; npcop = 2'd0; cmp = 1'b0; likely = 1'b0;
      tick("rst");
      reset = 1'b0;
      tick("rel");
   endtask

   initial begin
      tick("rst0");
      tick("rst1");
      chk("t1_pc", bus.PC_F, 32'h3000);
      chk("t1_instr", bus.Instr_D, 32'h0);
      chk("t1_pc8", bus.PC8_D, 32'h8);
      reset = 1'b0;
      tick("t1a"); chk("t1_pc_a", bus.PC_F, 32'h3004);
      tick("t1b"); chk("t1_pc_b", bus.PC_F, 32'h3008);
      tick("t1c"); chk("t1_pc_c", bus.PC_F, 32'h300C);
      restart();
      npcop = 2'd1; cmp = 1'b1; imm26 = 26'h0004;
      tick("t2a");
      chk("t2_tgt", bus.PC_F, 32'h3014);
      chk("t2_slot", bus.PC_D, 32'h3004);
      restart();
      npcop = 2'd1; cmp = 1'b1; imm26 = 26'h000FFFF;
      tick("t2b");
      chk("t2_back", bus.PC_F, 32'h3000);
      restart();
      npcop = 2'd2; imm26 = 26'h0000C10;
      chk("t3_link", bus.PC8_D, 32'h3008);
      tick("t3a");
      chk("t3_jtgt", bus.PC_F, 32'h3040);
      npcop = 2'd3; rdata1 = 32'h3102;
      tick("t3b");
      chk("t3_jr", bus.PC_F, 32'h3102);
      chk("t3_adel", {31'd0, bus.AdEL_F}, 32'd1);
      restart();
      npcop = 2'd1; cmp = 1'b1; imm26 = 26'h0004; stall = 1'b1;
      tick("t4s0");
      tick("t4s1");
      chk("t4_hold", bus.PC_F, 32'h3004);
      stall = 1'b0;
      tick("t4go");
      chk("t4_redir", bus.PC_F, 32'h3014);
      restart();
      npcop = 2'd2; imm26 = 26'h0000C10; reset = 1'b1;
      tick("t5");
      chk("t5_pc", bus.PC_F, 32'h3000);
      chk("t5_instr", bus.Instr_D, 32'h0);
      restart();
      npcop = 2'd1; likely = 1'b1; cmp = 1'b0;
      tick("t6");
      chk("t6_pc", bus.PC_F, 32'h3008);
      chk("t6_instr", bus.Instr_D, LIKELY_EN ? 32'h0 : ~32'h3004);
      npcop = 2'd3; rdata1 = 32'hFFFF_FFFC; likely = 1'b0;
      tick("wrap_a");
      npcop = 2'd0;
      tick("wrap_b");
      chk("wrap_pc", bus.PC_F, 32'h0);
      for (int i = 0; i < 300; i++) begin
         reset  = ($urandom_range(31) == 0);
         stall  = ($urandom_range(3) == 0);
         npcop  = 2'($urandom_range(3));
         cmp    = 1'($urandom);
         likely = 1'($urandom);
         imm26  = 26'($urandom);
         rdata1 = $urandom_range(3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
         tick("rand");
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
